// File: rtl/clock_display_mux_if.sv
// Digit/alarm inputs and display/buzzer outputs of the multiplexed display driver.
// No valid/ready: inputs are level signals sampled on clock; outputs update every clock.
interface clock_display_mux_if;
  logic [7:0] ms_hour;
  logic [7:0] ls_hour;
  logic [7:0] ms_minute;
  logic [7:0] ls_minute;
  logic       alarm_sound;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       buzzer;

  modport master (
    output ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound,
    input  seg, an, dp, buzzer
  );

  modport slave (
    input  ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound,
    output seg, an, dp, buzzer
  );
endinterface

// File: rtl/clock_display_mux.sv
// Four-digit common-anode seven-segment scan driver with frame snapshot,
// blinking colon, alarm flash and square-wave buzzer.
module clock_display_mux #(
  parameter int SCAN_DIV     = 256,
  parameter int BLINK_FRAMES = 64,
  parameter int TONE_DIV     = 8,
  parameter int LZ_BLANK     = 1
) (
  input logic                 clock,
  input logic                 reset,
  clock_display_mux_if.slave  bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic          blink;
  logic [TW-1:0] tone_cnt;
  logic          tone_wrap;
  logic [7:0]    sh_ms_hour, sh_ls_hour, sh_ms_minute, sh_ls_minute;

  logic [7:0] cur_char;
  logic [3:0] cur_an;
  logic [6:0] digit_seg;
  logic       guard;
  logic       flash;
  logic       colon_on;

  function automatic logic [6:0] decode(input logic [7:0] ch);
    case (ch)
      8'h30:   decode = 7'h40;
      8'h31:   decode = 7'h79;
      8'h32:   decode = 7'h24;
      8'h33:   decode = 7'h30;
      8'h34:   decode = 7'h19;
      8'h35:   decode = 7'h12;
      8'h36:   decode = 7'h02;
      8'h37:   decode = 7'h78;
      8'h38:   decode = 7'h00;
      8'h39:   decode = 7'h10;
      8'h20:   decode = 7'h7F;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    cur_char = sh_ms_hour;
    cur_an   = 4'b0111;
    case (idx)
      2'd0: begin cur_char = sh_ms_hour;   cur_an = 4'b0111; end
      2'd1: begin cur_char = sh_ls_hour;   cur_an = 4'b1011; end
      2'd2: begin cur_char = sh_ms_minute; cur_an = 4'b1101; end
      default: begin cur_char = sh_ls_minute; cur_an = 4'b1110; end
    endcase
    digit_seg = decode(cur_char);
    if ((LZ_BLANK != 0) && (idx == 2'd0) && (cur_char == 8'h30))
      digit_seg = 7'h7F;
    // The first cycle of every slot is dark so the previous digit cannot ghost.
    guard    = (scan_cnt == '0);
    flash    = bus.alarm_sound && !blink;
    colon_on = bus.alarm_sound || blink;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt     <= '0;
      idx          <= 2'd0;
      frame_cnt    <= '0;
      blink        <= 1'b1;
      tone_cnt     <= '0;
      tone_wrap    <= 1'b0;
      sh_ms_hour   <= 8'h20;
      sh_ls_hour   <= 8'h20;
      sh_ms_minute <= 8'h20;
      sh_ls_minute <= 8'h20;
      bus.seg      <= 7'h7F;
      bus.an       <= 4'hF;
      bus.dp       <= 1'b1;
      bus.buzzer   <= 1'b0;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
        if (idx == 2'd3) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            blink     <= !blink;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // Snapshot at frame start keeps all four digits of one frame consistent.
      if (guard && (idx == 2'd0)) begin
        sh_ms_hour   <= bus.ms_hour;
        sh_ls_hour   <= bus.ls_hour;
        sh_ms_minute <= bus.ms_minute;
        sh_ls_minute <= bus.ls_minute;
      end

      if (guard) begin
        bus.seg <= 7'h7F;
        bus.an  <= 4'hF;
        bus.dp  <= 1'b1;
      end else begin
        bus.seg <= flash ? 7'h7F : digit_seg;
        bus.an  <= cur_an;
        bus.dp  <= !((idx == 2'd1) && colon_on);
      end

      // tone_wrap delays each toggle one cycle so the first lands TONE_DIV edges after alarm start.
      if (bus.alarm_sound) begin
        if (tone_cnt == TONE_LAST) tone_cnt <= '0;
        else                       tone_cnt <= tone_cnt + 1'b1;
        tone_wrap <= (tone_cnt == TONE_LAST);
        if (tone_wrap) bus.buzzer <= !bus.buzzer;
      end else begin
        tone_cnt   <= '0;
        tone_wrap  <= 1'b0;
        bus.buzzer <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench for clock_display_mux (SCAN_DIV=4, BLINK_FRAMES=2, TONE_DIV=2):
// stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_clock_display_mux;
  logic clock = 1'b0;
  logic reset = 1'b0;

  clock_display_mux_if dbus ();

  clock_display_mux #(
    .SCAN_DIV(4), .BLINK_FRAMES(2), .TONE_DIV(2), .LZ_BLANK(1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dbus.slave)
  );

  always #5 clock = ~clock;

  // {seg, an, dp, buzzer}
  logic [12:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          bj = 0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one output word per clock while enabled.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      cyc++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_underflow @%0t: got empty queue expected an entry", $time);
      end else begin
        check($sformatf("out_c%0d", cyc), {19'd0, dbus.seg, dbus.an, dbus.dp, dbus.buzzer},
              {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_digits(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
    dbus.ms_hour   = a;
    dbus.ls_hour   = b;
    dbus.ms_minute = c;
    dbus.ls_minute = d;
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic colon, input logic flash, input logic alarm);
    logic [6:0] segs [4];
    logic [3:0] ans  [4];
    logic       bz;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    ans[0] = 4'b0111; ans[1] = 4'b1011; ans[2] = 4'b1101; ans[3] = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        bz = 1'b0;
        if (alarm) begin
          bz = ((bj >> 1) & 1) != 0;
          bj++;
        end
        if (c == 0)
          exp_q.push_back({7'h7F, 4'hF, 1'b1, bz});
        else
          exp_q.push_back({flash ? 7'h7F : segs[i], ans[i],
                           !((i == 1) && colon), bz});
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    set_digits("1", "2", "3", "4");
    dbus.alarm_sound = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_seg", {25'd0, dbus.seg}, 32'h7F);
    check("rst_an", {28'd0, dbus.an}, 32'hF);
    check("rst_dp", {31'd0, dbus.dp}, 32'h1);
    check("rst_buzzer", {31'd0, dbus.buzzer}, 32'h0);

    wait_cycles(2);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Frame 0: "1234", blink on.
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0, 1'b0);
    wait_cycles(16);
    // Frame 1: ls_minute changes inside idx1 slot; not shown until frame 2.
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0, 1'b0);
    wait_cycles(6);
    dbus.ls_minute = "5";
    wait_cycles(10);
    // Frame 2: blink off, new digit visible.
    push_frame(7'h79, 7'h24, 7'h30, 7'h12, 1'b0, 1'b0, 1'b0);
    wait_cycles(16);
    // Frame 3: leading-zero blank, space, illegal character, '9'.
    set_digits("0", 8'h20, 8'h41, "9");
    push_frame(7'h7F, 7'h7F, 7'h3F, 7'h10, 1'b0, 1'b0, 1'b0);
    wait_cycles(16);
    // Frames 4-6: alarm active; blink on for 4-5, flash during 6.
    set_digits("0", "7", "4", "5");
    dbus.alarm_sound = 1'b1;
    bj = 0;
    push_frame(7'h7F, 7'h78, 7'h19, 7'h12, 1'b1, 1'b0, 1'b1);
    wait_cycles(16);
    push_frame(7'h7F, 7'h78, 7'h19, 7'h12, 1'b1, 1'b0, 1'b1);
    wait_cycles(16);
    push_frame(7'h7F, 7'h78, 7'h19, 7'h12, 1'b1, 1'b1, 1'b1);
    wait_cycles(16);
    // Frame 7: alarm dropped, buzzer silent from the next edge, blink off.
    dbus.alarm_sound = 1'b0;
    push_frame(7'h7F, 7'h78, 7'h19, 7'h12, 1'b0, 1'b0, 1'b0);
    wait_cycles(16);

    // Mid-frame reset while the buzzer is high.
    mon_en = 1'b0;
    dbus.alarm_sound = 1'b1;
    wait_cycles(4);
    check("buzz_before_rst", {31'd0, dbus.buzzer}, 32'h1);
    reset = 1'b1;
    #1;
    check("midrst_seg", {25'd0, dbus.seg}, 32'h7F);
    check("midrst_an", {28'd0, dbus.an}, 32'hF);
    check("midrst_dp", {31'd0, dbus.dp}, 32'h1);
    check("midrst_buzzer", {31'd0, dbus.buzzer}, 32'h0);
    dbus.alarm_sound = 1'b0;
    set_digits("1", "2", "3", "4");
    wait_cycles(1);
    reset  = 1'b0;
    mon_en = 1'b1;
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0, 1'b0);
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1'b0, 1'b0);
    wait_cycles(32);
    mon_en = 1'b0;
    wait_cycles(1);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Four-digit multiplexed seven-segment display driver. It sits directly downstream of `alarm_clock_top` and consumes its ASCII digit outputs (`ms_hour`, `ls_hour`, `ms_minute`, `ls_minute`) and `alarm_sound`. It time-multiplexes the digits onto one common-anode segment bus, drives a blinking colon, flashes the display while the alarm sounds, and generates a square-wave buzzer drive.

## Interface
- `SCAN_DIV`, 256: clock cycles per digit slot; minimum 2.
- `BLINK_FRAMES`, 64: full 4-digit frames per blink half-period; minimum 1.
- `TONE_DIV`, 8: clock cycles per buzzer half-period; minimum 1.
- `LZ_BLANK`, 1: when 1, an ASCII '0' on `ms_hour` is displayed blank.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ms_hour` in 8: ASCII hour tens digit.
- `ls_hour` in 8: ASCII hour units digit.
- `ms_minute` in 8: ASCII minute tens digit.
- `ls_minute` in 8: ASCII minute units digit.
- `alarm_sound` in 1: alarm active, same clock domain.
- `seg` out 7: active-low segments, {g,f,e,d,c,b,a}.
- `an` out 4: active-low digit enables; `an[3]` is the leftmost digit.
- `dp` out 1: active-low colon, shown on the `ls_hour` slot only.
- `buzzer` out 1: buzzer square wave.

## Operation
- **Counters**
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - On wrap, `idx` advances 0→1→2→3→0.
  - On `idx` 3→0, `frame_cnt` advances 0..BLINK_FRAMES-1.
  - On `frame_cnt` wrap, `blink` toggles.
- **Slot mapping**
  - idx0: `ms_hour`, `an`=4'b0111.
  - idx1: `ls_hour`, `an`=4'b1011.
  - idx2: `ms_minute`, `an`=4'b1101.
  - idx3: `ls_minute`, `an`=4'b1110.
- **Snapshot**
  - All four inputs are captured into shadow registers on the edge where `scan_cnt`==0 and `idx`==0 (frame start).
  - This prevents tearing within a frame. Input changes mid-frame are shown from the next frame.
- **Decode** (ASCII to `seg`)
  - 0x30-0x39 → digit pattern: '0'=7'h40, '1'=7'h79, '2'=7'h24, '3'=7'h30, '4'=7'h19, '5'=7'h12, '6'=7'h02, '7'=7'h78, '8'=7'h00, '9'=7'h10.
  - 0x20 → blank, 7'h7F.
  - Any other value → dash, 7'h3F.
  - With LZ_BLANK=1, an `ms_hour` snapshot of 0x30 → 7'h7F.
- **Ghost guard**: while `scan_cnt`==0, `an`=4'hF and `seg`=7'h7F.
- **Colon** (`dp`=0 only in slot idx1, outside the guard cycle)
  - `alarm_sound`=0: colon lit when `blink`=1.
  - `alarm_sound`=1: colon lit steadily.
- **Alarm flash**: while `alarm_sound`=1 and `blink`=0, `seg`=7'h7F in all slots. `an` keeps scanning.
- **Buzzer**
  - While `alarm_sound`=1, `tone_cnt` counts 0..TONE_DIV-1 and `buzzer` toggles on each wrap.
  - While `alarm_sound`=0, `tone_cnt` is held at 0 and `buzzer` is held at 0.

## Timing
- **Reset values** (async, applied immediately, any state):
  - Outputs: `seg`=7'h7F, `an`=4'hF, `dp`=1, `buzzer`=0.
  - Internal: `scan_cnt`=0, `idx`=0, `frame_cnt`=0, `blink`=1, `tone_cnt`=0, shadows=8'h20.
- **After reset release**
  - First rising edge: snapshot captured, `scan_cnt`→1.
  - Outputs are registered and reflect the state from the previous cycle.
  - `an` first goes active (4'b0111) on the edge after the one that set `scan_cnt`=1, i.e. 2 edges after release.
- **Slot length**: each digit is enabled SCAN_DIV-1 cycles, then 1 guard cycle.
- **Frame and blink period**
  - Frame = 4·SCAN_DIV cycles.
  - Blink half-period = BLINK_FRAMES·4·SCAN_DIV cycles.
- **Buzzer**
  - Rising edge of `alarm_sound` seen at edge N: first `buzzer` toggle at edge N+TONE_DIV.
  - Falling edge: `buzzer`=0 from the next edge.
- **Reset mid-frame**: the partial frame is discarded and scanning restarts at idx0 with blank shadows.
- **Mid-slot input change**: has no effect until the next frame start.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_FRAMES=2, TONE_DIV=2.
1. **Reset**: assert `reset` mid-scan → outputs 7'h7F / 4'hF / 1 / 0 in the same cycle. Release with inputs "1234" → `an` sequence 0111,1011,1101,1110 with `seg` 79,24,30,19, each preceded by one 4'hF guard cycle.
2. **Snapshot**: inputs "1234" → change `ls_minute` to '5' during slot idx1 → that frame still shows 7'h19 in idx3; the next frame shows 7'h12.
3. **Decode edges**: `ms_hour`=0x30 with LZ_BLANK=1 → idx0 `seg`=7'h7F. `ms_minute`=0x41 → 7'h3F. `ls_hour`=0x20 → 7'h7F.
4. **Colon blink**: `alarm_sound`=0 → `dp`=0 in idx1 for 2 frames (32 cycles), then `dp`=1 for 2 frames. `dp`=1 in all other slots.
5. **Alarm**: raise `alarm_sound` → `buzzer` toggles every 2 cycles. During `blink`=0 frames, all `seg`=7'h7F while `an` scans. `dp` stays 0 in idx1. Drop `alarm_sound` → `buzzer`=0 on the next edge.
